ip_hdr_check: RTL and testbench

IP_HDR_CHECK -- requirements
Module: ip_hdr_check

---
 rtl/ip_hdr_check.sv | 146 ++++++++++++++
 tb/tb_ip_hdr_check.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_hdr_check.sv
// IPv4 header checker: walks a byte stream, sums 16-bit words for the header
// checksum and captures length, protocol and address fields.
module ip_hdr_check #(
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic [7:0]  rx_data,
    output logic        done,
    output logic        chk_ok,
    output logic        fmt_err,
    output logic [3:0]  ip_hdr_len,
    output logic [15:0] ip_total_len,
    output logic [7:0]  ip_protocol,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip
);

    typedef enum logic {IDLE, HDR} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] acc;
    logic [7:0]  hi;
    logic [3:0]  ihl;
    logic [15:0] tl_s;
    logic [7:0]  proto_s;
    logic [31:0] src_s;
    logic [31:0] dst_s;

    logic        start;
    logic        take;
    logic        last;
    logic        ver_ok;
    logic        sum_ok;
    logic        len_bad;
    logic [5:0]  idx;
    logic [5:0]  hdr_bytes;
    logic [31:0] acc_n;
    logic [15:0] tl_n;
    logic [7:0]  proto_n;
    logic [31:0] src_n;
    logic [31:0] dst_n;
    logic [16:0] fold1;
    logic [16:0] fold2;

    assign start     = rx_valid & rx_sof;
    assign take      = rx_valid & (rx_sof | (state == HDR));
    assign idx       = start ? 6'd0 : cnt;
    assign hdr_bytes = {ihl, 2'b00};
    assign last      = rx_valid & ~rx_sof & (state == HDR) & (cnt == hdr_bytes - 6'd1);
    assign ver_ok    = (rx_data[7:4] == 4'd4) && (rx_data[3:0] >= 4'd5);

    // Next values of the accumulator and field staging, so the final byte of a
    // header is already folded in when the results are registered.
    always_comb begin
        acc_n   = start ? 32'd0 : acc;
        tl_n    = tl_s;
        proto_n = proto_s;
        src_n   = src_s;
        dst_n   = dst_s;
        if (take) begin
            if (idx[0]) begin
                acc_n = acc + {16'h0000, hi, rx_data};
            end
            case (idx)
                6'd2:    tl_n[15:8] = rx_data;
                6'd3:    tl_n[7:0]  = rx_data;
                6'd9:    proto_n    = rx_data;
                6'd12, 6'd13, 6'd14, 6'd15: src_n = {src_s[23:0], rx_data};
                6'd16, 6'd17, 6'd18, 6'd19: dst_n = {dst_s[23:0], rx_data};
                default: ;
            endcase
        end
    end

    // Two end-around folds are enough: the first leaves at most one carry bit.
    assign fold1   = {1'b0, acc_n[31:16]} + {1'b0, acc_n[15:0]};
    assign fold2   = {1'b0, fold1[15:0]} + {16'h0000, fold1[16]};
    assign sum_ok  = (fold2[15:0] == 16'hFFFF);
    assign len_bad = (tl_n < {10'd0, ihl, 2'b00});

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            acc          <= 32'd0;
            hi           <= 8'd0;
            ihl          <= 4'd0;
            tl_s         <= 16'd0;
            proto_s      <= 8'd0;
            src_s        <= 32'd0;
            dst_s        <= 32'd0;
            done         <= 1'b0;
            chk_ok       <= 1'b0;
            fmt_err      <= 1'b0;
            ip_hdr_len   <= 4'd0;
            ip_total_len <= 16'd0;
            ip_protocol  <= 8'd0;
            src_ip       <= 32'd0;
            dst_ip       <= 32'd0;
        end else begin
            done    <= 1'b0;
            acc     <= acc_n;
            tl_s    <= tl_n;
            proto_s <= proto_n;
            src_s   <= src_n;
            dst_s   <= dst_n;
            if (take && !idx[0]) begin
                hi <= rx_data;
            end
            if (start) begin
                ihl <= rx_data[3:0];
                if (ver_ok) begin
                    state <= HDR;
                    cnt   <= 6'd1;
                end else begin
                    state      <= IDLE;
                    cnt        <= 6'd0;
                    done       <= 1'b1;
                    fmt_err    <= 1'b1;
                    chk_ok     <= (VERIFY_EN == 1'b0);
                    ip_hdr_len <= rx_data[3:0];
                end
            end else if (state == HDR && rx_valid) begin
                if (last) begin
                    state        <= IDLE;
                    cnt          <= 6'd0;
                    done         <= 1'b1;
                    chk_ok       <= VERIFY_EN ? sum_ok : 1'b1;
                    fmt_err      <= len_bad;
                    ip_hdr_len   <= ihl;
                    ip_total_len <= tl_n;
                    ip_protocol  <= proto_n;
                    src_ip       <= src_n;
                    dst_ip       <= dst_n;
                end else begin
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_hdr_check.sv
// Bench for ip_hdr_check: directed and random headers scored against a
// byte-array model of IPv4 header rules; a VERIFY_EN=0 copy runs alongside.
module tb_ip_hdr_check;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    logic        done, chk_ok, fmt_err;
    logic [3:0]  ip_hdr_len;
    logic [15:0] ip_total_len;
    logic [7:0]  ip_protocol;
    logic [31:0] src_ip, dst_ip;

    logic        done_nv, chk_nv, fmt_nv;
    logic [3:0]  hl_nv;
    logic [15:0] tl_nv;
    logic [7:0]  pr_nv;
    logic [31:0] src_nv, dst_nv;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          full;
        bit          fmt;
        bit          chk;
        logic [3:0]  hl;
        logic [15:0] tl;
        logic [7:0]  pr;
        logic [31:0] src;
        logic [31:0] dst;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  hdr [0:63];

    ip_hdr_check dut (
        .clk(clk), .reset_p(reset_p), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_data(rx_data), .done(done), .chk_ok(chk_ok), .fmt_err(fmt_err),
        .ip_hdr_len(ip_hdr_len), .ip_total_len(ip_total_len),
        .ip_protocol(ip_protocol), .src_ip(src_ip), .dst_ip(dst_ip)
    );

    ip_hdr_check #(.VERIFY_EN(1'b0)) dut_nv (
        .clk(clk), .reset_p(reset_p), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_data(rx_data), .done(done_nv), .chk_ok(chk_nv), .fmt_err(fmt_nv),
        .ip_hdr_len(hl_nv), .ip_total_len(tl_nv),
        .ip_protocol(pr_nv), .src_ip(src_nv), .dst_ip(dst_nv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: ones-complement sum of the header words must be all ones.
    function automatic exp_t model();
        exp_t e;
        int   n;
        int   s;
        e = '{default: 0};
        e.hl = hdr[0][3:0];
        if (hdr[0][7:4] != 4'd4 || hdr[0][3:0] < 4'd5) begin
            e.full = 1'b0;
            e.fmt  = 1'b1;
            e.chk  = 1'b0;
            return e;
        end
        n = 4 * int'(e.hl);
        s = 0;
        for (int i = 0; i < n; i += 2) begin
            s += int'({hdr[i], hdr[i+1]});
            if (s > 65535) s -= 65535;
        end
        e.full = 1'b1;
        e.chk  = (s == 65535);
        e.tl   = {hdr[2], hdr[3]};
        e.fmt  = (int'(e.tl) < n);
        e.pr   = hdr[9];
        e.src  = {hdr[12], hdr[13], hdr[14], hdr[15]};
        e.dst  = {hdr[16], hdr[17], hdr[18], hdr[19]};
        return e;
    endfunction

    task automatic fill_csum(input int n);
        int         s;
        logic [15:0] c;
        hdr[10] = 8'd0;
        hdr[11] = 8'd0;
        s = 0;
        for (int i = 0; i < n; i += 2) begin
            s += int'({hdr[i], hdr[i+1]});
            if (s > 65535) s -= 65535;
        end
        c = 16'(65535 - s);
        hdr[10] = c[15:8];
        hdr[11] = c[7:0];
    endtask

    task automatic load_base();
        logic [159:0] base;
        base = 160'h45000073000040004011B861C0A80001C0A800C7;
        for (int i = 0; i < 20; i++) hdr[i] = base[159 - 8*i -: 8];
        for (int i = 20; i < 64; i++) hdr[i] = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_sof   = sof;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic send_junk(input int n);
        repeat (n) send_byte(8'($urandom), 1'b0);
    endtask

    task automatic send_hdr(input int nbytes, input int gap_pct);
        exp_t e;
        int   last;
        e = model();
        last = e.full ? 4 * int'(e.hl) - 1 : 0;
        for (int i = 0; i < nbytes; i++) begin
            if (i > 0) begin
                while (int'($urandom_range(99, 0)) < gap_pct) idle(1);
            end
            send_byte(hdr[i], i == 0);
            if (i == last) begin
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_chk"}, 32'(chk_ok), 32'd0);
        check({tag, "_fmt"}, 32'(fmt_err), 32'd0);
        check({tag, "_hl"}, 32'(ip_hdr_len), 32'd0);
        check({tag, "_tl"}, 32'(ip_total_len), 32'd0);
        check({tag, "_pr"}, 32'(ip_protocol), 32'd0);
        check({tag, "_src"}, src_ip, 32'd0);
        check({tag, "_dst"}, dst_ip, 32'd0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.due);
                check("fmt_err", 32'(fmt_err), 32'(mon_e.fmt));
                check("chk_ok", 32'(chk_ok), 32'(mon_e.chk));
                if (mon_e.full) begin
                    check("ip_hdr_len", 32'(ip_hdr_len), 32'(mon_e.hl));
                    check("ip_total_len", 32'(ip_total_len), 32'(mon_e.tl));
                    check("ip_protocol", 32'(ip_protocol), 32'(mon_e.pr));
                    check("src_ip", src_ip, mon_e.src);
                    check("dst_ip", dst_ip, mon_e.dst);
                end
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            check("missing_done", 32'(done), 32'd1);
            mon_e = exp_q.pop_front();
        end
        if (done || done_nv) begin
            check("done_nv", 32'(done_nv), 32'(done));
            check("chk_nv", 32'(chk_nv), 32'd1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ihl;
        int n;
        int k;
        reset_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_p = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Reference header with a correct checksum.
        load_base();
        send_hdr(20, 0);
        idle(2);
        check("r030_chk", 32'(chk_ok), 32'd1);
        check("r030_fmt", 32'(fmt_err), 32'd0);
        check("r030_hl", 32'(ip_hdr_len), 32'd5);
        check("r030_tl", 32'(ip_total_len), 32'h0073);
        check("r030_pr", 32'(ip_protocol), 32'h11);
        check("r030_src", src_ip, 32'hC0A80001);
        check("r030_dst", dst_ip, 32'hC0A800C7);

        // Corrupted checksum byte.
        load_base();
        hdr[11] = 8'h62;
        send_hdr(20, 0);
        idle(2);
        check("r031_chk", 32'(chk_ok), 32'd0);
        check("r031_fmt", 32'(fmt_err), 32'd0);
        check("r031_chk_nv", 32'(chk_nv), 32'd1);

        // Bad version, then bad IHL; trailing bytes must be ignored.
        load_base();
        hdr[0] = 8'h65;
        send_hdr(1, 0);
        send_junk(19);
        idle(2);
        check("r032_v6_fmt", 32'(fmt_err), 32'd1);
        hdr[0] = 8'h44;
        send_hdr(1, 0);
        send_junk(19);
        idle(2);
        check("r032_ihl4_fmt", 32'(fmt_err), 32'd1);
        check("r032_ihl4_chk", 32'(chk_ok), 32'd0);

        // IHL=6 with options and stalls.
        load_base();
        hdr[0] = 8'h46;
        hdr[20] = 8'h01; hdr[21] = 8'h01; hdr[22] = 8'h01; hdr[23] = 8'h00;
        fill_csum(24);
        send_hdr(24, 15);
        idle(2);
        check("r033_chk", 32'(chk_ok), 32'd1);
        check("r033_hl", 32'(ip_hdr_len), 32'd6);

        // Restart at byte 10: only the second header completes.
        load_base();
        send_hdr(10, 0);
        send_hdr(20, 0);
        idle(2);
        check("r034_restart_chk", 32'(chk_ok), 32'd1);

        // Reset at byte 7 aborts silently.
        load_base();
        send_hdr(7, 0);
        @(posedge clk);
        #1;
        reset_p  = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        check_zero("r034_rst");
        send_junk(13);
        idle(3);
        check_zero("r034_after");

        // Valid checksum but total length shorter than the header.
        load_base();
        hdr[2] = 8'h00;
        hdr[3] = 8'h10;
        fill_csum(20);
        send_hdr(20, 0);
        idle(2);
        check("r035_chk", 32'(chk_ok), 32'd1);
        check("r035_fmt", 32'(fmt_err), 32'd1);

        // Random headers, sometimes back-to-back, sometimes malformed.
        repeat (60) begin
            ihl = int'($urandom_range(15, 5));
            for (int i = 1; i < 64; i++) hdr[i] = 8'($urandom);
            hdr[0] = {4'h4, 4'(ihl)};
            n = 4 * ihl;
            if ($urandom_range(3, 0) != 0) begin
                {hdr[2], hdr[3]} = 16'($urandom_range(65535, n));
            end else begin
                {hdr[2], hdr[3]} = 16'($urandom_range(n - 1, 0));
            end
            fill_csum(n);
            if ($urandom_range(3, 0) == 0) begin
                k = int'($urandom_range(n - 1, 1));
                hdr[k] = hdr[k] ^ 8'($urandom_range(255, 1));
            end
            if ($urandom_range(9, 0) == 0) begin
                hdr[0] = 8'($urandom);
                n = (hdr[0][7:4] == 4'd4 && hdr[0][3:0] >= 4'd5) ? 4 * int'(hdr[0][3:0]) : 20;
            end
            send_hdr(n, int'($urandom_range(20, 0)));
            if ($urandom_range(2, 0) != 0) begin
                idle(int'($urandom_range(3, 1)));
                send_junk(int'($urandom_range(4, 0)));
                idle(1);
            end
        end

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
